// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if
//   Bundles the requester-side and comparator-side signals of cmp_arbiter.
//   The clock and reset stay outside as plain ports.
//
//   Requester side : req, a_in, b_in -> gnt, ack, res_lt/eq/gt/err, busy
//   Comparator side: cmp_op, cmp_l, cmp_e, cmp_g -> cmp_rst, cmp_load, cmp_a, cmp_b
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (requesting units plus the shared comparator)
interface cmp_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    // Requester side
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           res_lt;
    logic           res_eq;
    logic           res_gt;
    logic           res_err;
    logic           busy;

    // Comparator side
    logic           cmp_rst;
    logic           cmp_load;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           cmp_op;
    logic           cmp_l;
    logic           cmp_e;
    logic           cmp_g;

    modport slave (
        input  req, a_in, b_in, cmp_op, cmp_l, cmp_e, cmp_g,
        output gnt, ack, res_lt, res_eq, res_gt, res_err, busy,
               cmp_rst, cmp_load, cmp_a, cmp_b
    );

    modport master (
        output req, a_in, b_in, cmp_op, cmp_l, cmp_e, cmp_g,
        input  gnt, ack, res_lt, res_eq, res_gt, res_err, busy,
               cmp_rst, cmp_load, cmp_a, cmp_b
    );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter
//   Round-robin arbiter and sequencer that shares one bit-serial magnitude
//   comparator among N requesters. For each transaction it grants one
//   requester, latches that requester's operands, clears and then loads the
//   comparator, and waits for its done flag (or a timeout). It then returns
//   the result with a one-cycle acknowledge.
//
//   Ports:
//     clk  - system clock, all state on the rising edge
//     rst  - asynchronous active-low reset
//     bus  - cmp_arbiter_if.slave (requests, operands, grants, acks, results,
//            and the comparator control/status lines)
module cmp_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 48
) (
    input  logic          clk,
    input  logic          rst,
    cmp_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [N-1:0]       ack_q, ack_d;
    logic               res_lt_q, res_lt_d;
    logic               res_eq_q, res_eq_d;
    logic               res_gt_q, res_gt_d;
    logic               res_err_q, res_err_d;
    logic               cmp_rst_q, cmp_rst_d;
    logic               cmp_load_q, cmp_load_d;
    logic [W-1:0]       cmp_a_q, cmp_a_d;
    logic [W-1:0]       cmp_b_q, cmp_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               timeout;

    // Round-robin pick: the first set request bit at or above ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        res_lt_d  = res_lt_q;
        res_eq_d  = res_eq_q;
        res_gt_d  = res_gt_q;
        res_err_d = res_err_q;
        cmp_a_d   = cmp_a_q;
        cmp_b_d   = cmp_b_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    gnt_d   = N'(1) << pick_idx;
                    // Operands are frozen here; later changes on a_in/b_in
                    // cannot disturb the running comparison.
                    cmp_a_d = bus.a_in[pick_idx*W +: W];
                    cmp_b_d = bus.b_in[pick_idx*W +: W];
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.cmp_op || timeout) begin
                    // Result and ack are registered together so both are
                    // valid during the single DONE cycle.
                    ack_d   = gnt_q;
                    state_d = S_DONE;
                    if (bus.cmp_op) begin
                        res_lt_d  = bus.cmp_l;
                        res_eq_d  = bus.cmp_e;
                        res_gt_d  = bus.cmp_g;
                        res_err_d = !$onehot({bus.cmp_l, bus.cmp_e, bus.cmp_g});
                    end else begin
                        res_lt_d  = 1'b0;
                        res_eq_d  = 1'b0;
                        res_gt_d  = 1'b0;
                        res_err_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = (win_q == IDX_W'(N - 1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Comparator strobes are registered from the next state so they line up
    // exactly with the CLEAR and LOAD cycles.
    assign cmp_rst_d  = (state_d == S_CLEAR);
    assign cmp_load_d = (state_d == S_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            res_lt_q   <= 1'b0;
            res_eq_q   <= 1'b0;
            res_gt_q   <= 1'b0;
            res_err_q  <= 1'b0;
            // Held high through reset and until the first edge after
            // release, so the comparator starts out cleared.
            cmp_rst_q  <= 1'b1;
            cmp_load_q <= 1'b0;
            cmp_a_q    <= '0;
            cmp_b_q    <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            res_lt_q   <= res_lt_d;
            res_eq_q   <= res_eq_d;
            res_gt_q   <= res_gt_d;
            res_err_q  <= res_err_d;
            cmp_rst_q  <= cmp_rst_d;
            cmp_load_q <= cmp_load_d;
            cmp_a_q    <= cmp_a_d;
            cmp_b_q    <= cmp_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.res_lt   = res_lt_q;
    assign bus.res_eq   = res_eq_q;
    assign bus.res_gt   = res_gt_q;
    assign bus.res_err  = res_err_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.cmp_rst  = cmp_rst_q;
    assign bus.cmp_load = cmp_load_q;
    assign bus.cmp_a    = cmp_a_q;
    assign bus.cmp_b    = cmp_b_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter
//   Self-checking bench for cmp_arbiter. It contains a behavioural stand-in
//   for the shared bit-serial comparator and a transaction-level model of the
//   arbiter. One compare process checks every output on every falling edge,
//   and directed tests add hand-computed literal expectations.
module tb_cmp_arbiter;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    cmp_arbiter_if #(.N(N), .W(W)) bus ();

    cmp_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Comparator stand-in: cleared by cmp_rst, samples operands on the
    // falling edge while cmp_load is high, and raises OP once 32 cycles have
    // passed since the clear. tmo_mode suppresses OP. bad_mode forces L=G=1.
    // ------------------------------------------------------------------
    bit          tmo_mode = 1'b0;
    bit          bad_mode = 1'b0;
    logic [5:0]  c_cnt;
    logic [W-1:0] c_a, c_b;
    logic        c_op;

    always @(posedge clk) begin
        if (bus.cmp_rst) c_cnt <= '0;
        else if (c_cnt != 6'd63) c_cnt <= c_cnt + 6'd1;
    end

    always @(negedge clk) begin
        if (bus.cmp_load) begin
            c_a <= bus.cmp_a;
            c_b <= bus.cmp_b;
        end
    end

    assign c_op       = (c_cnt >= 6'(W));
    assign bus.cmp_op = !tmo_mode && c_op;
    assign bus.cmp_l  = bad_mode ? 1'b1 : (c_op && (c_a < c_b));
    assign bus.cmp_e  = bad_mode ? 1'b0 : (c_op && (c_a == c_b));
    assign bus.cmp_g  = bad_mode ? 1'b1 : (c_op && (c_a > c_b));

    // ------------------------------------------------------------------
    // Transaction-level model. A transaction that starts at the end of IDLE
    // cycle c keeps the arbiter busy for cycles c+1 .. c+lat, with CLEAR at
    // c+1, LOAD at c+2, and ack/result in cycle c+lat. lat is W+3 with the
    // stand-in comparator and TIMEOUT+3 when OP never rises.
    // ------------------------------------------------------------------
    int           cyc     = 0;
    int           ended;
    bit           m_busy  = 1'b0;
    bit           m_hold  = 1'b1;
    int           m_ptr   = 0;
    int           m_win   = 0;
    int           m_start = 0;
    int           m_done  = 0;
    bit           found;
    logic [3:0]   m_pend  = '0;   // {lt, eq, gt, err}
    logic [3:0]   m_res   = '0;
    logic [W-1:0] m_ca    = '0;
    logic [W-1:0] m_cb    = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_busy = 1'b0;
                m_ptr  = 0;
                m_res  = '0;
                m_ca   = '0;
                m_cb   = '0;
                m_hold = 1'b1;
            end else begin
                ended  = cyc;
                cyc    = cyc + 1;
                m_hold = 1'b0;
                if (!m_busy && bus.req != '0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && bus.req[(m_ptr + k) % N]) begin
                            found = 1'b1;
                            m_win = (m_ptr + k) % N;
                        end
                    end
                    m_ca    = bus.a_in[m_win*W +: W];
                    m_cb    = bus.b_in[m_win*W +: W];
                    m_start = ended;
                    m_done  = ended + (tmo_mode ? TIMEOUT + 3 : W + 3);
                    if (tmo_mode)      m_pend = 4'b0001;
                    else if (bad_mode) m_pend = 4'b1011;
                    else               m_pend = {m_ca < m_cb, m_ca == m_cb, m_ca > m_cb, 1'b0};
                    m_busy = 1'b1;
                end else if (m_busy && ended == m_done) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_win + 1) % N;
                end else if (m_busy && ended == m_done - 1) begin
                    m_res = m_pend;
                end
            end
        end
    end

    // Compare process: every output, every cycle, on the falling edge.
    logic [N-1:0] e_gnt, e_ack;
    initial begin
        forever begin
            @(negedge clk);
            e_gnt = m_busy ? N'(1) << m_win : '0;
            e_ack = (m_busy && cyc == m_done) ? e_gnt : '0;
            check("cyc_gnt",      bus.gnt, e_gnt);
            check("cyc_ack",      bus.ack, e_ack);
            check("cyc_busy",     bus.busy, m_busy);
            check("cyc_cmp_rst",  bus.cmp_rst, m_hold || (m_busy && cyc == m_start + 1));
            check("cyc_cmp_load", bus.cmp_load, m_busy && cyc == m_start + 2);
            check("cyc_cmp_a",    bus.cmp_a, m_ca);
            check("cyc_cmp_b",    bus.cmp_b, m_cb);
            check("cyc_res",      {bus.res_lt, bus.res_eq, bus.res_gt, bus.res_err}, m_res);
            check("cyc_gnt_onehot0", $onehot0(bus.gnt), 1'b1);
            check("cyc_ack_in_gnt",  bus.ack & ~bus.gnt, '0);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
    endtask

    // Entered on the falling edge of an IDLE cycle (cycle 0). Returns on the
    // falling edge of the IDLE cycle after the ack.
    task automatic run_txn(input string name, input logic [N-1:0] r, input int exp_lat,
                           input logic [N-1:0] exp_ack, input logic [3:0] exp_res,
                           input bit scramble);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        bus.req = r;
        while (!got && lat < 80) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({name, "_gnt_c1"}, bus.gnt, exp_ack);
            if (bus.ack != '0) begin
                got = 1'b1;
            end else if (scramble) begin
                bus.req = '0;
                for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
            end
        end
        check({name, "_ack_seen"}, got, 1'b1);
        if (got) begin
            check({name, "_lat"}, lat, exp_lat);
            check({name, "_ack"}, bus.ack, exp_ack);
            check({name, "_res"}, {bus.res_lt, bus.res_eq, bus.res_gt, bus.res_err}, exp_res);
        end
        bus.req = '0;
        @(negedge clk);
    endtask

    logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] rr_got [5];

    initial begin
        int  n;
        bit  got;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;

        repeat (3) @(negedge clk);
        check("rst_gnt",      bus.gnt, '0);
        check("rst_busy",     bus.busy, 1'b0);
        check("rst_cmp_rst",  bus.cmp_rst, 1'b1);
        check("rst_cmp_load", bus.cmp_load, 1'b0);
        check("rst_res",      {bus.res_lt, bus.res_eq, bus.res_gt, bus.res_err}, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        check("rel_cmp_rst", bus.cmp_rst, 1'b0);

        set_ops(0, 32'h0000_0005, 32'h0000_0009);
        run_txn("single", 4'b0001, W + 3, 4'b0001, 4'b1000, 1'b0);
        set_ops(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_txn("equal", 4'b0001, W + 3, 4'b0001, 4'b0100, 1'b0);
        set_ops(0, 32'h8000_0000, 32'h7FFF_FFFF);
        run_txn("greater", 4'b0001, W + 3, 4'b0001, 4'b0010, 1'b0);
        set_ops(3, 32'h0000_0001, 32'h0000_0002);
        run_txn("wrap3", 4'b1000, W + 3, 4'b1000, 4'b1000, 1'b0);

        // Round robin with all four requesting continuously.
        set_ops(0, 32'd10, 32'd20);
        set_ops(1, 32'd7, 32'd7);
        set_ops(2, 32'd9, 32'd3);
        set_ops(3, 32'hFFFF_FFFF, 32'd0);
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            n   = 0;
            while (!got && n < 60) begin
                @(negedge clk);
                n++;
                if (bus.ack != '0) got = 1'b1;
            end
            check("rr_ack_seen", got, 1'b1);
            rr_got[g] = bus.ack;
        end
        bus.req = '0;
        @(negedge clk);
        for (int g = 0; g < 5; g++) check($sformatf("rr_order%0d", g), rr_got[g], rr_exp[g]);

        // Operands and req disturbed after grant; result follows grant-time values.
        set_ops(1, 32'd100, 32'd50);
        run_txn("stable", 4'b0010, W + 3, 4'b0010, 4'b0010, 1'b1);

        tmo_mode = 1'b1;
        set_ops(2, 32'd3, 32'd3);
        run_txn("timeout", 4'b0100, TIMEOUT + 3, 4'b0100, 4'b0001, 1'b0);
        tmo_mode = 1'b0;

        bad_mode = 1'b1;
        set_ops(3, 32'd5, 32'd6);
        run_txn("badhot", 4'b1000, W + 3, 4'b1000, 4'b1011, 1'b0);
        bad_mode = 1'b0;

        // Move ptr to 2, then abort a transaction of requester 0 mid-RUN.
        set_ops(1, 32'd4, 32'd4);
        run_txn("pre_rst", 4'b0010, W + 3, 4'b0010, 4'b0100, 1'b0);
        set_ops(0, 32'd1, 32'd1000);
        bus.req = 4'b0001;
        repeat (10) @(negedge clk);
        check("mid_busy", bus.busy, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_gnt",     bus.gnt, '0);
        check("arst_busy",    bus.busy, 1'b0);
        check("arst_ack",     bus.ack, '0);
        check("arst_cmp_rst", bus.cmp_rst, 1'b1);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // ptr is back at 0, so requester 0 wins over requester 3.
        set_ops(0, 32'd2, 32'd1);
        set_ops(3, 32'd1, 32'd2);
        run_txn("post_rst", 4'b1001, W + 3, 4'b0001, 4'b0010, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
